// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// Serialises one FRAME_BITS-wide status frame as consecutive 8N1 UART bytes.
// The least-significant byte goes first, there is no gap between bytes, and
// the line idles high.
//
// Optional feature: define UART_FRAME_TX_CHECKSUM_EN to append one extra byte.
// It is the XOR of all frame bytes and is sent after the last frame byte.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_frame_valid  a frame is offered
//   i_frame        frame payload, sampled on acceptance
//   o_frame_ready  high while idle (state == IDLE)
//   o_tx           serial line, registered, idle high
//   o_busy         registered, high while a frame is in flight
//   o_done         registered one-cycle pulse after the final stop bit
module uart_frame_tx #(
    parameter int BUS_SIZE   = 32,
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int DVSR       = 108,
    parameter int FRAME_BITS = BUS_SIZE + 3 * DATA_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_frame_valid,
    input  logic [FRAME_BITS-1:0] i_frame,
    output logic                  o_frame_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NBYTES = FRAME_BITS / DATA_BITS;
`ifdef UART_FRAME_TX_CHECKSUM_EN
    localparam int LAST_BYTE = NBYTES;        // checksum byte follows the frame
`else
    localparam int LAST_BYTE = NBYTES - 1;
`endif
    localparam int CNT_W = (DVSR > 1)      ? $clog2(DVSR)      : 1;
    localparam int SUB_W = (SB_TICKS > 1)  ? $clog2(SB_TICKS)  : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int IDX_W = (LAST_BYTE > 0) ? $clog2(LAST_BYTE + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DVSR - 1);
    localparam logic [SUB_W-1:0] SUB_MAX  = SUB_W'(SB_TICKS - 1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_BYTE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;     // clocks within one tick
    logic [SUB_W-1:0]      sub_q;     // ticks within one bit
    logic [BIT_W-1:0]      bit_q;     // data bit within the byte
    logic [IDX_W-1:0]      byte_q;    // byte within the frame
    logic [FRAME_BITS-1:0] shift_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  tick;

`ifdef UART_FRAME_TX_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CHK_IDX = IDX_W'(NBYTES - 1);
    logic [DATA_BITS-1:0] chk_d;
    logic [DATA_BITS-1:0] chk_q;

    always_comb begin
        chk_d = '0;
        for (int i = 0; i < NBYTES; i++) begin
            chk_d = chk_d ^ i_frame[i*DATA_BITS +: DATA_BITS];
        end
    end
`endif

    assign tick          = (state_q != S_IDLE) && (cnt_q == CNT_MAX);
    assign o_frame_ready = (state_q == S_IDLE);
    assign o_tx          = tx_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

    // The line outputs are updated on the same edge as the state, so o_tx
    // always shows the level of the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sub_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_FRAME_TX_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (i_frame_valid) begin
                        shift_q <= i_frame;
                        cnt_q   <= '0;
                        sub_q   <= '0;
                        bit_q   <= '0;
                        byte_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
`ifdef UART_FRAME_TX_CHECKSUM_EN
                        chk_q   <= chk_d;
`endif
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (sub_q == SUB_MAX) begin
                            sub_q   <= '0;
                            bit_q   <= '0;
                            tx_q    <= shift_q[0];
                            state_q <= S_DATA;
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end
                end

                // The frame shifts one bit per data bit, so after a full byte
                // it has moved right by DATA_BITS and bit 0 is the next byte.
                S_DATA: begin
                    if (tick) begin
                        if (sub_q == SUB_MAX) begin
                            sub_q   <= '0;
                            shift_q <= shift_q >> 1;
                            if (bit_q == BIT_MAX) begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                                tx_q  <= shift_q[1];
                            end
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        if (sub_q == SUB_MAX) begin
                            sub_q <= '0;
                            if (byte_q == LAST_IDX) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                byte_q  <= byte_q + IDX_W'(1);
                                tx_q    <= 1'b0;
                                state_q <= S_START;
`ifdef UART_FRAME_TX_CHECKSUM_EN
                                // Frame fully shifted out: send the checksum next.
                                if (byte_q == CHK_IDX) begin
                                    shift_q <= FRAME_BITS'(chk_q);
                                end
`endif
                            end
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
`timescale 1ns/1ps
module tb_uart_frame_tx;

    localparam int DV = 3;
    localparam int SB = 2;
    localparam int BP = DV * SB;          // clocks per bit
    localparam int NB = 7;                // frame bytes
`ifdef UART_FRAME_TX_CHECKSUM_EN
    localparam int NB_TX = NB + 1;
`else
    localparam int NB_TX = NB;
`endif
    localparam int NBITS = NB_TX * 10;
    localparam int FLEN  = NBITS * BP;
    localparam int BLEN  = NBITS;         // DVSR=1, SB_TICKS=1 instance

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_frame_valid;
    logic [55:0] i_frame;
    logic        o_frame_ready, o_tx, o_busy, o_done;
    logic        b_valid;
    logic [55:0] b_frame;
    logic        b_ready, b_tx, b_busy, b_done;

    always #5 clk = ~clk;

    uart_frame_tx #(.DVSR(DV), .SB_TICKS(SB)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_frame_valid(i_frame_valid), .i_frame(i_frame),
        .o_frame_ready(o_frame_ready), .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    uart_frame_tx #(.DVSR(1), .SB_TICKS(1)) dut_min (
        .i_clk(clk), .i_reset(i_reset), .i_frame_valid(b_valid), .i_frame(b_frame),
        .o_frame_ready(b_ready), .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Expected line = per-frame list of 8N1 bits, each lasting BP clocks,
    // indexed by clocks elapsed since acceptance.
    logic        s_reset, s_valid;
    logic [55:0] s_frame;
    bit          chk_en = 1'b0;
    bit          m_active = 1'b0;
    int          m_cyc = 0;
    int          m_acc_cnt = 0;
    int          m_done_cnt = 0;
    logic        m_bits [NBITS];
    bit          rx_on = 1'b0;
    int          rx_c = 0;
    logic [7:0]  rx_byte;
    logic [7:0]  rx_q [$];

    always @(posedge clk) begin
        s_reset <= i_reset;
        s_valid <= i_frame_valid;
        s_frame <= i_frame;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] b, x;
            logic [3:0] exp_v;
            bit         done_e;
            int         k;
            done_e = 1'b0;
            if (s_reset) begin
                m_active = 1'b0;
                rx_on    = 1'b0;
                rx_q.delete();
            end else if (!m_active) begin
                if (s_valid) begin
                    m_active = 1'b1;
                    m_cyc    = 0;
                    m_acc_cnt++;
                    x = 8'h00;
                    for (int j = 0; j < NB_TX; j++) begin
                        b = (j < NB) ? s_frame[j*8 +: 8] : x;
                        x = x ^ b;
                        m_bits[j*10] = 1'b0;
                        for (int i = 0; i < 8; i++) m_bits[j*10+1+i] = b[i];
                        m_bits[j*10+9] = 1'b1;
                    end
                end
            end else begin
                m_cyc++;
                if (m_cyc == FLEN) begin
                    m_active = 1'b0;
                    done_e   = 1'b1;
                    m_done_cnt++;
                end
            end
            exp_v = {!m_active, m_active, done_e, m_active ? m_bits[m_cyc/BP] : 1'b1};
            check("line{ready,busy,done,tx}", 64'({o_frame_ready, o_busy, o_done, o_tx}), 64'(exp_v));

            // host-side receiver: mid-bit sampling of the DUT line
            if (!s_reset) begin
                if (!rx_on) begin
                    if (o_tx == 1'b0) begin
                        rx_on = 1'b1;
                        rx_c  = 0;
                    end
                end else begin
                    rx_c++;
                    if (rx_c % BP == BP / 2) begin
                        k = rx_c / BP;
                        if (k >= 1 && k <= 8) rx_byte[k-1] = o_tx;
                        if (k == 9) begin
                            rx_q.push_back(rx_byte);
                            rx_on = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit presented = 1'b0;

    function automatic logic [7:0] xor_bytes(input logic [55:0] f);
        logic [7:0] x = 8'h00;
        for (int k = 0; k < NB; k++) x = x ^ f[k*8 +: 8];
        return x;
    endfunction

    task automatic do_frame(input logic [55:0] f, input bit hold, input logic [55:0] nxt,
                            input logic [7:0] sum);
        int n, a0, d0;
        logic [7:0] b, x;
        a0 = m_acc_cnt;
        d0 = m_done_cnt;
        if (!presented) begin
            i_frame_valid = 1'b1;
            i_frame       = f;
        end
        n = 0;
        while (m_acc_cnt == a0 && n < 50) begin step(); n++; end
        if (m_acc_cnt == a0) begin
            vectors++; miscompares++;
            $display("FAIL accept: frame %h not accepted within 50 cycles", f);
            i_frame_valid = 1'b0;
            presented = 1'b0;
            return;
        end
        if (hold) begin
            i_frame   = nxt;           // next frame offered while this one is in flight
            presented = 1'b1;
        end else begin
            i_frame_valid = 1'b0;
            i_frame   = 56'({$urandom(), $urandom()});
            presented = 1'b0;
        end
        n = 0;
        while (m_done_cnt == d0 && n < FLEN + 20) begin step(); n++; end
        check("done_pulse", 64'(o_done), 64'(1));
        check("rx_count", 64'(rx_q.size()), 64'(NB_TX));
        x = 8'h00;
        for (int k = 0; k < NB_TX; k++) begin
            b = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            if (k < NB) begin
                check("rx_byte", 64'(b), 64'(f[k*8 +: 8]));
                x = x ^ b;
            end else begin
                check("rx_checksum", 64'(b), 64'(sum));
            end
        end
        check("rx_xor", 64'(x), 64'(sum));
        $display("frame %h hold=%0d xor=%h rx_xor=%h", f, hold, sum, x);
    endtask

    typedef struct {
        logic [55:0] frame;
        bit          hold;
        logic [7:0]  sum;
    } vec_t;

    initial begin
        vec_t        tbl [5];
        logic [55:0] rf [13];
        logic [9:0]  seq;
        int          n, cnt, dcount, a0;

        tbl[0] = '{56'h06050403020100, 1'b0, 8'h07};
        tbl[1] = '{56'h00000000001BD3, 1'b1, 8'hC8};
        tbl[2] = '{56'hFFFFFFFFFFFFFF, 1'b0, 8'hFF};
        tbl[3] = '{56'h000000000000A5, 1'b0, 8'hA5};
        tbl[4] = '{56'h123456789ABCDE, 1'b0, 8'hF0};

        i_reset = 1'b1; i_frame_valid = 1'b0; i_frame = '0;
        b_valid = 1'b0; b_frame = '0;
        chk_en  = 1'b1;
        repeat (5) step();
        i_reset = 1'b0;
        repeat (100) step();
        $display("reset/idle window done");

        for (int i = 0; i < 5; i++)
            do_frame(tbl[i].frame, tbl[i].hold, (i < 4) ? tbl[i+1].frame : 56'h0, tbl[i].sum);

        // reset during bit 3 of byte 2
        a0 = m_acc_cnt;
        i_frame_valid = 1'b1;
        i_frame = 56'h0123456789ABCD;
        n = 0;
        while (m_acc_cnt == a0 && n < 50) begin step(); n++; end
        i_frame_valid = 1'b0;
        n = 0;
        while (m_cyc < (2*10 + 1 + 3) * BP + 2 && n < FLEN) begin step(); n++; end
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("rst_tx", 64'(o_tx), 64'(1));
        check("rst_busy", 64'(o_busy), 64'(0));
        dcount = 0;
        repeat (3 * 10 * BP) begin step(); dcount += int'(o_done); end
        check("rst_no_done", 64'(dcount), 64'(0));
        presented = 1'b0;
        $display("reset mid-frame done");

        // randomized frames, random gaps, random back-to-back
        for (int r = 0; r < 13; r++) rf[r] = 56'({$urandom(), $urandom()});
        for (int r = 0; r < 12; r++) begin
            bit hold;
            hold = (r < 11) ? bit'($urandom_range(0, 1)) : 1'b0;
            if (!presented) repeat ($urandom_range(0, 3)) step();
            do_frame(rf[r], hold, rf[r+1], xor_bytes(rf[r]));
        end

        // minimum timing instance: one clock per bit
        b_valid = 1'b1;
        b_frame = 56'hA5;
        check("b_ready", 64'(b_ready), 64'(1));
        step();
        b_valid = 1'b0;
        b_frame = '1;
        cnt = 0;
        seq = '0;
        while (b_busy && cnt < 200) begin
            if (cnt < 10) seq[cnt] = b_tx;
            cnt++;
            step();
        end
        check("b_bits", 64'(seq), 64'(10'b1101001010));
        check("b_len", 64'(cnt), 64'(BLEN));
        check("b_done", 64'(b_done), 64'(1));
        $display("min-timing frame a5 bits=%b len=%0d", seq, cnt);

        repeat (5) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
